// File: rtl/serial_operand_loader.sv
// Serial-to-parallel operand loader around an external combinational adder:
// shifts A then B in MSB first, captures {carry, sum} and offers it on a valid/ready handshake.
module serial_operand_loader #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ser_in,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   output logic [WIDTH:0]   result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   result_q, result_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = valid_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_A;
               cnt_d   = '0;
            end
         end
         LOAD_A: begin
            a_d   = {a_q[WIDTH-2:0], ser_in};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = LOAD_B;
               cnt_d   = '0;
            end
         end
         LOAD_B: begin
            b_d   = {b_q[WIDTH-2:0], ser_in};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end
         end
         CAPTURE: begin
            // Operands have been stable for a full cycle, so the adder output has settled.
            result_d = {carry_in, sum_in};
            valid_d  = 1'b1;
            state_d  = HOLD;
         end
         HOLD: begin
            if (result_ready) begin
               valid_d = 1'b0;
               if (start) begin
                  state_d = LOAD_A;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign a_out        = a_q;
   assign b_out        = b_q;
   assign result       = result_q;
   assign result_valid = valid_q;
   assign busy         = busy_q;

endmodule
